// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: FSM states and next-PC mux encoding.
package ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    TRAP  = 2'd2
  } ctrl_state_t;

  typedef logic [1:0] pc_sel_t;

  localparam pc_sel_t PC_PLUS4  = 2'b00;
  localparam pc_sel_t PC_BRANCH = 2'b01;
  localparam pc_sel_t PC_TRAP   = 2'b10;
  localparam pc_sel_t PC_MEPC   = 2'b11;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Pipeline-side bundle: hazard/branch/irq status into the controller, stall/flush/PC-select out.
interface pipeline_ctrl_if
  import ctrl_pkg::*;
#(
  parameter int XLEN = 32
);
  logic [4:0]      id_rs1_addr;
  logic [4:0]      id_rs2_addr;
  logic            id_use_rs1;
  logic            id_use_rs2;
  logic [4:0]      ex_rd_addr;
  logic            ex_mem_ren;
  logic            br_taken_EX;
  logic            mret_EX;
  logic [XLEN-1:0] pc_ID;
  logic            irq_pending;
  logic            irq_enable;
  logic            mem_busy;

  logic            stall_PC;
  logic            stall_ID;
  logic            flush_ID;
  logic            flush_EX;
  logic            freeze;
  pc_sel_t         pc_sel;
  logic [XLEN-1:0] mepc;
  logic            irq_ack;
  logic            in_handler;

  // master is the pipeline datapath, slave is the controller
  modport master (
    output id_rs1_addr, id_rs2_addr, id_use_rs1, id_use_rs2, ex_rd_addr, ex_mem_ren,
           br_taken_EX, mret_EX, pc_ID, irq_pending, irq_enable, mem_busy,
    input  stall_PC, stall_ID, flush_ID, flush_EX, freeze, pc_sel, mepc, irq_ack, in_handler
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_use_rs1, id_use_rs2, ex_rd_addr, ex_mem_ren,
           br_taken_EX, mret_EX, pc_ID, irq_pending, irq_enable, mem_busy,
    output stall_PC, stall_ID, flush_ID, flush_EX, freeze, pc_sel, mepc, irq_ack, in_handler
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard: a load in EX whose rd is read by the instruction in ID cannot be forwarded in time.
module hazard_detect (
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd_addr,
  input  logic       ex_mem_ren,
  output logic       load_use
);

  logic w_hit_rs1;
  logic w_hit_rs2;

  assign w_hit_rs1 = id_use_rs1 & (ex_rd_addr == id_rs1_addr);
  assign w_hit_rs2 = id_use_rs2 & (ex_rd_addr == id_rs2_addr);
  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign load_use  = ex_mem_ren & (ex_rd_addr != 5'd0) & (w_hit_rs1 | w_hit_rs2);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes, SRAM freeze and
// interrupt entry (drain -> trap redirect) / mret return.
module pipeline_ctrl
  import ctrl_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              DRAIN_CYCLES = 3,
  parameter logic [XLEN-1:0] TRAP_VEC     = 'h0000_0100
)(
  input  logic            clk,
  input  logic            rst_n,
  pipeline_ctrl_if.slave  bus
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  // The PC mux owns TRAP_VEC; this block only selects it, so just sanity-check it here.
  generate
    if (TRAP_VEC[1:0] != 2'b00) begin : g_bad_trap_vec
      $error("pipeline_ctrl: TRAP_VEC must be word aligned");
    end
    if (DRAIN_CYCLES < 1) begin : g_bad_drain
      $error("pipeline_ctrl: DRAIN_CYCLES must be at least 1");
    end
  endgenerate

  ctrl_state_t     r_state,      w_state_next;
  logic [CNT_W-1:0] r_cnt,       w_cnt_next;
  logic [XLEN-1:0] r_mepc,       w_mepc_next;
  logic            r_in_handler, w_in_handler_next;

  logic    w_load_use;
  logic    w_irq_accept;
  logic    w_stall_pc, w_stall_id, w_flush_id, w_flush_ex, w_freeze, w_irq_ack;
  pc_sel_t w_pc_sel;

  hazard_detect u_hazard_detect (
    .id_rs1_addr (bus.id_rs1_addr),
    .id_rs2_addr (bus.id_rs2_addr),
    .id_use_rs1  (bus.id_use_rs1),
    .id_use_rs2  (bus.id_use_rs2),
    .ex_rd_addr  (bus.ex_rd_addr),
    .ex_mem_ren  (bus.ex_mem_ren),
    .load_use    (w_load_use)
  );

  assign w_irq_accept = bus.irq_pending & bus.irq_enable & ~r_in_handler
                      & ~bus.br_taken_EX & ~bus.mret_EX;

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_mepc_next       = r_mepc;
    w_in_handler_next = r_in_handler;
    w_stall_pc        = 1'b0;
    w_stall_id        = 1'b0;
    w_flush_id        = 1'b0;
    w_flush_ex        = 1'b0;
    w_freeze          = 1'b0;
    w_pc_sel          = PC_PLUS4;
    w_irq_ack         = 1'b0;

    if (!rst_n) begin
      w_flush_id = 1'b1;
      w_flush_ex = 1'b1;
    end else if (bus.mem_busy) begin
      // Whole pipeline holds; any pending redirect is re-evaluated once the SRAM is free
      w_freeze   = 1'b1;
      w_stall_pc = 1'b1;
      w_stall_id = 1'b1;
    end else begin
      unique case (r_state)
        RUN: begin
          if (bus.br_taken_EX) begin
            w_pc_sel   = PC_BRANCH;
            w_flush_id = 1'b1;
            w_flush_ex = 1'b1;
          end else if (bus.mret_EX) begin
            if (r_in_handler) begin
              w_pc_sel          = PC_MEPC;
              w_flush_id        = 1'b1;
              w_flush_ex        = 1'b1;
              w_in_handler_next = 1'b0;
            end
          end else if (w_irq_accept) begin
            // ID instruction is discarded and replayed from mepc after mret
            w_mepc_next  = bus.pc_ID;
            w_stall_pc   = 1'b1;
            w_flush_id   = 1'b1;
            w_flush_ex   = 1'b1;
            w_cnt_next   = CNT_W'(DRAIN_CYCLES - 1);
            w_state_next = DRAIN;
          end else if (w_load_use) begin
            w_stall_pc = 1'b1;
            w_stall_id = 1'b1;
            w_flush_ex = 1'b1;
          end
        end
        DRAIN: begin
          w_stall_pc = 1'b1;
          w_flush_id = 1'b1;
          w_flush_ex = 1'b1;
          if (r_cnt == '0) begin
            w_state_next = TRAP;
          end else begin
            w_cnt_next = r_cnt - 1'b1;
          end
        end
        TRAP: begin
          w_pc_sel          = PC_TRAP;
          w_flush_id        = 1'b1;
          w_irq_ack         = 1'b1;
          w_in_handler_next = 1'b1;
          w_state_next      = RUN;
        end
        default: w_state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= RUN;
      r_cnt        <= '0;
      r_mepc       <= '0;
      r_in_handler <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_mepc       <= w_mepc_next;
      r_in_handler <= w_in_handler_next;
    end
  end

  assign bus.stall_PC   = w_stall_pc;
  assign bus.stall_ID   = w_stall_id;
  assign bus.flush_ID   = w_flush_id;
  assign bus.flush_EX   = w_flush_ex;
  assign bus.freeze     = w_freeze;
  assign bus.pc_sel     = w_pc_sel;
  assign bus.irq_ack    = w_irq_ack;
  assign bus.mepc       = r_mepc;
  assign bus.in_handler = r_in_handler;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: single-cycle RUN-state vector table plus irq/freeze/reset sequences.
module tb_pipeline_ctrl;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  pipeline_ctrl_if #(.XLEN(32)) bus ();

  pipeline_ctrl #(
    .XLEN         (32),
    .DRAIN_CYCLES (3),
    .TRAP_VEC     (32'h0000_0100)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       ren;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       br;
    logic       mret;
    logic       irqp;
    logic       irqe;
    logic       busy;
    logic       spc;
    logic       sid;
    logic       fid;
    logic       fex;
    logic       frz;
    logic [1:0] psel;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect7(input string tag, input logic spc, input logic sid, input logic fid,
                         input logic fex, input logic frz, input logic [1:0] psel, input logic ack);
    chk({tag, ".stall_PC"}, 32'(bus.stall_PC), 32'(spc));
    chk({tag, ".stall_ID"}, 32'(bus.stall_ID), 32'(sid));
    chk({tag, ".flush_ID"}, 32'(bus.flush_ID), 32'(fid));
    chk({tag, ".flush_EX"}, 32'(bus.flush_EX), 32'(fex));
    chk({tag, ".freeze"},   32'(bus.freeze),   32'(frz));
    chk({tag, ".pc_sel"},   32'(bus.pc_sel),   32'(psel));
    chk({tag, ".irq_ack"},  32'(bus.irq_ack),  32'(ack));
  endtask

  task automatic clr_inputs();
    bus.id_rs1_addr = '0;
    bus.id_rs2_addr = '0;
    bus.id_use_rs1  = 1'b0;
    bus.id_use_rs2  = 1'b0;
    bus.ex_rd_addr  = '0;
    bus.ex_mem_ren  = 1'b0;
    bus.br_taken_EX = 1'b0;
    bus.mret_EX     = 1'b0;
    bus.pc_ID       = '0;
    bus.irq_pending = 1'b0;
    bus.irq_enable  = 1'b0;
    bus.mem_busy    = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    //          name          ren rd    rs1   rs2   u1 u2 br mret irqp irqe busy spc sid fid fex frz psel
    vecs[0]  = '{"ld_rs1",     1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0,   0,   0,   0,   1,  1,  0,  1,  0,  2'b00};
    vecs[1]  = '{"ld_rd0",     1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0,   0,   0,   0,   0,  0,  0,  0,  0,  2'b00};
    vecs[2]  = '{"ld_rs2",     1, 5'd7, 5'd3, 5'd7, 0, 1, 0, 0,   0,   0,   0,   1,  1,  0,  1,  0,  2'b00};
    vecs[3]  = '{"rs2_unused", 1, 5'd7, 5'd3, 5'd7, 1, 0, 0, 0,   0,   0,   0,   0,  0,  0,  0,  0,  2'b00};
    vecs[4]  = '{"not_load",   0, 5'd5, 5'd5, 5'd5, 1, 1, 0, 0,   0,   0,   0,   0,  0,  0,  0,  0,  2'b00};
    vecs[5]  = '{"br_over_lu", 1, 5'd5, 5'd5, 5'd0, 1, 0, 1, 0,   0,   0,   0,   0,  0,  1,  1,  0,  2'b01};
    vecs[6]  = '{"mret_nop",   0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1,   0,   0,   0,   0,  0,  0,  0,  0,  2'b00};
    vecs[7]  = '{"irq_masked", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,   1,   0,   0,   0,  0,  0,  0,  0,  2'b00};
    vecs[8]  = '{"busy_br",    0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0,   0,   0,   1,   1,  1,  0,  0,  1,  2'b00};
    vecs[9]  = '{"irq_vs_br",  0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0,   1,   1,   0,   0,  0,  1,  1,  0,  2'b01};
    vecs[10] = '{"busy_irq",   0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0,   1,   1,   1,   1,  1,  0,  0,  1,  2'b00};

    clr_inputs();
    rst_n = 1'b0;

    // Reset
    @(negedge clk);
    #2;
    expect7("rst", 0, 0, 1, 1, 0, 2'b00, 0);
    chk("rst.mepc", bus.mepc, 32'h0);
    chk("rst.in_handler", 32'(bus.in_handler), 32'h0);
    $display("[TB] reset: flush_ID=%0b flush_EX=%0b mepc=%0h", bus.flush_ID, bus.flush_EX, bus.mepc);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle RUN-state vectors; none of them may start an interrupt entry
    for (int i = 0; i < 11; i++) begin
      bus.ex_mem_ren  = vecs[i].ren;
      bus.ex_rd_addr  = vecs[i].rd;
      bus.id_rs1_addr = vecs[i].rs1;
      bus.id_rs2_addr = vecs[i].rs2;
      bus.id_use_rs1  = vecs[i].u1;
      bus.id_use_rs2  = vecs[i].u2;
      bus.br_taken_EX = vecs[i].br;
      bus.mret_EX     = vecs[i].mret;
      bus.irq_pending = vecs[i].irqp;
      bus.irq_enable  = vecs[i].irqe;
      bus.mem_busy    = vecs[i].busy;
      bus.pc_ID       = 32'h0000_0040;
      #2;
      expect7(vecs[i].name, vecs[i].spc, vecs[i].sid, vecs[i].fid, vecs[i].fex, vecs[i].frz,
              vecs[i].psel, 1'b0);
      $display("[TB] vec %s: stall_PC=%0b stall_ID=%0b flush_ID=%0b flush_EX=%0b freeze=%0b pc_sel=%0d",
               vecs[i].name, bus.stall_PC, bus.stall_ID, bus.flush_ID, bus.flush_EX, bus.freeze, bus.pc_sel);
      @(negedge clk);
    end
    clr_inputs();
    #2;
    chk("table.mepc", bus.mepc, 32'h0);
    chk("table.in_handler", 32'(bus.in_handler), 32'h0);
    expect7("lu_clear", 0, 0, 0, 0, 0, 2'b00, 0);
    @(negedge clk);

    // Interrupt entry: accept, 3 drain cycles, trap
    bus.pc_ID       = 32'h0000_0040;
    bus.irq_pending = 1'b1;
    bus.irq_enable  = 1'b1;
    #2;
    expect7("irq_acc", 1, 0, 1, 1, 0, 2'b00, 0);
    $display("[TB] irq accept at pc_ID=%0h stall_PC=%0b", bus.pc_ID, bus.stall_PC);
    @(negedge clk);
    bus.irq_pending = 1'b0;
    bus.pc_ID       = 32'h0000_0044;
    for (int i = 0; i < 3; i++) begin
      #2;
      expect7($sformatf("drain%0d", i), 1, 0, 1, 1, 0, 2'b00, 0);
      chk($sformatf("drain%0d.mepc", i), bus.mepc, 32'h40);
      chk($sformatf("drain%0d.in_handler", i), 32'(bus.in_handler), 32'h0);
      $display("[TB] drain %0d: stall_PC=%0b irq_ack=%0b", i, bus.stall_PC, bus.irq_ack);
      @(negedge clk);
    end
    #2;
    expect7("trap", 0, 0, 1, 0, 0, 2'b10, 1);
    $display("[TB] trap: pc_sel=%0d irq_ack=%0b", bus.pc_sel, bus.irq_ack);
    @(negedge clk);
    #2;
    expect7("handler", 0, 0, 0, 0, 0, 2'b00, 0);
    chk("handler.mepc", bus.mepc, 32'h40);
    chk("handler.in_handler", 32'(bus.in_handler), 32'h1);
    $display("[TB] handler: mepc=%0h in_handler=%0b", bus.mepc, bus.in_handler);

    // Nested interrupt must be ignored while in the handler
    bus.irq_pending = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      expect7($sformatf("nest%0d", i), 0, 0, 0, 0, 0, 2'b00, 0);
      $display("[TB] nested irq cycle %0d: stall_PC=%0b", i, bus.stall_PC);
      @(negedge clk);
    end

    // mret returns; the still-pending irq is then accepted
    bus.mret_EX = 1'b1;
    #2;
    expect7("mret", 0, 0, 1, 1, 0, 2'b11, 0);
    $display("[TB] mret: pc_sel=%0d", bus.pc_sel);
    @(negedge clk);
    bus.mret_EX = 1'b0;
    bus.pc_ID   = 32'h0000_0080;
    #2;
    chk("ret.in_handler", 32'(bus.in_handler), 32'h0);
    expect7("irq2_acc", 1, 0, 1, 1, 0, 2'b00, 0);
    $display("[TB] second irq accept at pc_ID=%0h", bus.pc_ID);
    @(negedge clk);
    bus.pc_ID = 32'h0000_0084;
    #2;
    expect7("irq2_drain_c2", 1, 0, 1, 1, 0, 2'b00, 0);
    @(negedge clk);

    // Freeze for 4 cycles while the drain counter sits at 1
    bus.mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      expect7($sformatf("frz%0d", i), 1, 1, 0, 0, 1, 2'b00, 0);
      $display("[TB] freeze cycle %0d: freeze=%0b", i, bus.freeze);
      @(negedge clk);
    end
    bus.mem_busy = 1'b0;
    #2;
    expect7("post_frz_c1", 1, 0, 1, 1, 0, 2'b00, 0);
    @(negedge clk);
    #2;
    expect7("post_frz_c0", 1, 0, 1, 1, 0, 2'b00, 0);
    @(negedge clk);
    #2;
    expect7("frz_trap", 0, 0, 1, 0, 0, 2'b10, 1);
    $display("[TB] trap after freeze: pc_sel=%0d irq_ack=%0b", bus.pc_sel, bus.irq_ack);
    @(negedge clk);
    #2;
    chk("h2.mepc", bus.mepc, 32'h80);
    chk("h2.in_handler", 32'(bus.in_handler), 32'h1);
    expect7("h2", 0, 0, 0, 0, 0, 2'b00, 0);

    // Leave handler, accept a third irq and reset during its drain
    bus.mret_EX = 1'b1;
    #2;
    expect7("mret2", 0, 0, 1, 1, 0, 2'b11, 0);
    @(negedge clk);
    bus.mret_EX = 1'b0;
    bus.pc_ID   = 32'h0000_00C0;
    #2;
    expect7("irq3_acc", 1, 0, 1, 1, 0, 2'b00, 0);
    @(negedge clk);
    bus.irq_pending = 1'b0;
    #2;
    chk("irq3.mepc", bus.mepc, 32'hC0);
    expect7("irq3_drain", 1, 0, 1, 1, 0, 2'b00, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    expect7("rst_drain", 0, 0, 1, 1, 0, 2'b00, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("rst_drain.mepc", bus.mepc, 32'h0);
    chk("rst_drain.in_handler", 32'(bus.in_handler), 32'h0);
    $display("[TB] reset in drain: mepc=%0h in_handler=%0b", bus.mepc, bus.in_handler);
    for (int i = 0; i < 4; i++) begin
      expect7($sformatf("post_rst%0d", i), 0, 0, 0, 0, 0, 2'b00, 0);
      @(negedge clk);
      #2;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
